// File: rtl/keypad_scan_pkg.sv
// rtl/keypad_scan_pkg.sv - shared keypad geometry constants and key typedefs
package keypad_scan_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEY_NUM  = 16;

    typedef logic [3:0]         key_idx_t;
    typedef logic [KEY_NUM-1:0] key_vec_t;
endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - 16-to-4 lowest-index priority encoder with nonzero flag
module key_prio_enc
    import keypad_scan_pkg::*;
(
    input  key_vec_t vec_i,
    output key_idx_t idx_o,
    output logic     any_o
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = key_idx_t'(i);
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad scanner with frame debounce; KEYPAD_RELEASE_EVT_EN adds key_rel
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [15:0] key,
    output logic [3:0]  key_code,
    output logic        key_valid
`ifdef KEYPAD_RELEASE_EVT_EN
    ,
    output logic        key_rel
`endif
);

    localparam int         DIV_W = $clog2(CLK_DIV);
    localparam logic [3:0] DEB   = 4'(DEBOUNCE);

    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    key_vec_t         raw_q, raw_d, prev_q, key_q;
    logic [3:0]       stable_q, stable_d;
    key_idx_t         key_code_q;
    logic             key_valid_q;

    logic     slot_end, frame_end, commit;
    key_vec_t press_vec;
    key_idx_t press_idx;
    logic     press_any;

    assign slot_end  = (div_q == DIV_W'(CLK_DIV - 1));
    assign frame_end = slot_end && (col_q == 2'd3);

    // raw_d is the live frame; at frame end it already holds column 3's sample.
    always_comb begin
        raw_d = raw_q;
        if (slot_end) begin
            for (int r = 0; r < KEY_ROWS; r++) begin
                raw_d[KEY_COLS * r + int'(col_q)] = ~key_row[r];
            end
        end
    end

    always_comb begin
        stable_d = 4'd0;
        if (raw_d == prev_q) stable_d = (stable_q == DEB) ? DEB : stable_q + 4'd1;
    end

    assign commit    = frame_end && (stable_d == DEB) && (raw_d != key_q);
    assign press_vec = raw_d & ~key_q;

    key_prio_enc u_press_enc (
        .vec_i (press_vec),
        .idx_o (press_idx),
        .any_o (press_any)
    );

`ifdef KEYPAD_RELEASE_EVT_EN
    key_vec_t rel_vec;
    key_idx_t rel_idx, rel_code_q;
    logic     rel_any, rel_pend_q, key_rel_q;

    assign rel_vec = key_q & ~raw_d;

    key_prio_enc u_rel_enc (
        .vec_i (rel_vec),
        .idx_o (rel_idx),
        .any_o (rel_any)
    );

    assign key_rel = key_rel_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            col_q       <= 2'd0;
            raw_q       <= '0;
            prev_q      <= '0;
            stable_q    <= 4'd0;
            key_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_pend_q  <= 1'b0;
            rel_code_q  <= '0;
            key_rel_q   <= 1'b0;
`endif
        end else begin
            div_q       <= slot_end ? '0 : div_q + 1'b1;
            raw_q       <= raw_d;
            key_valid_q <= 1'b0;
            if (slot_end) col_q <= col_q + 2'd1;
            if (frame_end) begin
                prev_q   <= raw_d;
                stable_q <= stable_d;
            end
            if (commit) key_q <= raw_d;
            if (commit && press_any) begin
                key_valid_q <= 1'b1;
                key_code_q  <= press_idx;
            end
`ifdef KEYPAD_RELEASE_EVT_EN
            key_rel_q <= 1'b0;
            // A release sharing a commit with a press waits one cycle behind it.
            if (commit && rel_any) begin
                if (press_any) begin
                    rel_pend_q <= 1'b1;
                    rel_code_q <= rel_idx;
                end else begin
                    key_rel_q  <= 1'b1;
                    key_code_q <= rel_idx;
                end
            end else if (rel_pend_q) begin
                rel_pend_q <= 1'b0;
                key_rel_q  <= 1'b1;
                key_code_q <= rel_code_q;
            end
`endif
        end
    end

    assign key_col   = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule
